// File: rtl/ether_addr_pkg.sv
// Shared constants and loader state encoding for the station-address capture block.
package ether_addr_pkg;

  localparam int MAC_BYTES  = 6;
  localparam int IP_BYTES   = 4;
  localparam int ADDR_BYTES = MAC_BYTES + IP_BYTES;
  localparam int ADDR_W     = ADDR_BYTES * 8;
  localparam int MAC_W      = MAC_BYTES * 8;
  localparam int IP_W       = IP_BYTES * 8;

  localparam logic [7:0] BCAST_BYTE = 8'hff;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/dest_mac_match.sv
// Walks the first six bytes of each received frame and pulses on a station or broadcast hit.
module dest_mac_match
  import ether_addr_pkg::*;
#(
  parameter bit PROMISC = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  input  logic [MAC_W-1:0]  mac,
  input  logic              addr_valid,
  output logic              dest_match,
  output logic              dest_bcast
);

  logic [7:0] w_mac_byte [0:7];
  logic [2:0] r_idx;
  logic       r_match_acc;
  logic       r_bcast_acc;
  logic       r_av_start;
  logic       r_dest_match;
  logic       r_dest_bcast;

  // Byte k of mac is transmitted k-th (MSB first); slots 6 and 7 are never compared.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mac_byte
      if (gi < MAC_BYTES) begin : g_real
        assign w_mac_byte[gi] = mac[MAC_W-1-8*gi -: 8];
      end else begin : g_pad
        assign w_mac_byte[gi] = 8'h00;
      end
    end
  endgenerate

  logic w_first;
  logic w_match_run;
  logic w_bcast_run;
  logic w_av;

  assign w_first     = (r_idx == 3'd0);
  assign w_match_run = (rx_data == w_mac_byte[r_idx]) & (w_first | r_match_acc);
  assign w_bcast_run = (rx_data == BCAST_BYTE) & (w_first | r_bcast_acc);
  assign w_av        = w_first ? addr_valid : r_av_start;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx        <= 3'd0;
      r_match_acc  <= 1'b0;
      r_bcast_acc  <= 1'b0;
      r_av_start   <= 1'b0;
      r_dest_match <= 1'b0;
      r_dest_bcast <= 1'b0;
    end else begin
      r_dest_match <= 1'b0;
      r_dest_bcast <= 1'b0;
      if (!rx_dv) begin
        r_idx       <= 3'd0;
        r_match_acc <= 1'b0;
        r_bcast_acc <= 1'b0;
        r_av_start  <= 1'b0;
      end else begin
        // Index saturates at 6 so the pulse fires once per frame.
        if (r_idx != 3'd6) begin
          r_idx       <= r_idx + 3'd1;
          r_match_acc <= w_match_run;
          r_bcast_acc <= w_bcast_run;
          r_av_start  <= w_av;
        end
        if (r_idx == 3'd5) begin
          r_dest_match <= (w_match_run & w_av) | PROMISC;
          r_dest_bcast <= w_bcast_run;
        end
      end
    end
  end

  assign dest_match = r_dest_match;
  assign dest_bcast = r_dest_bcast;

endmodule

// File: rtl/address_capture.sv
// Loads the station MAC/IP from a strobed byte stream and flags frames addressed to it.
module address_capture
  import ether_addr_pkg::*;
#(
  parameter bit PROMISC = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        address_set,
  input  logic              rx_dv,
  input  logic [7:0]        rx_data,
  output logic [MAC_W-1:0]  mac,
  output logic [IP_W-1:0]   ip,
  output logic              addr_valid,
  output logic              load_err,
  output logic              dest_match,
  output logic              dest_bcast
);

  load_state_t       r_state;
  load_state_t       w_state_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_shift;
  logic [MAC_W-1:0]  r_mac;
  logic [IP_W-1:0]   r_ip;
  logic              r_addr_valid;
  logic              r_load_err;

  logic              w_strobe;
  logic [ADDR_W-1:0] w_shift_next;
  logic              w_last;

  assign w_strobe     = address_set[8];
  assign w_shift_next = {r_shift[ADDR_W-9:0], address_set[7:0]};
  assign w_last       = w_strobe && (r_state != LD_DONE) && (r_cnt == 4'(ADDR_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LD_IDLE: if (w_strobe) w_state_next = LD_LOAD;
      LD_LOAD: if (w_last)   w_state_next = LD_DONE;
      LD_DONE: w_state_next = LD_DONE;
      default: w_state_next = LD_IDLE;
    endcase
  end

  // mac/ip change only on the tenth strobe so consumers never see a half-loaded address.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt        <= 4'd0;
      r_shift      <= '0;
      r_mac        <= '0;
      r_ip         <= '0;
      r_addr_valid <= 1'b0;
      r_load_err   <= 1'b0;
    end else if (w_strobe) begin
      if (r_state == LD_DONE) begin
        r_load_err <= 1'b1;
      end else begin
        r_shift <= w_shift_next;
        r_cnt   <= r_cnt + 4'd1;
        if (w_last) begin
          r_mac        <= w_shift_next[ADDR_W-1 -: MAC_W];
          r_ip         <= w_shift_next[IP_W-1:0];
          r_addr_valid <= 1'b1;
        end
      end
    end
  end

  dest_mac_match #(
    .PROMISC (PROMISC)
  ) u_dest_mac_match (
    .clk        (clk),
    .rst        (rst),
    .rx_dv      (rx_dv),
    .rx_data    (rx_data),
    .mac        (r_mac),
    .addr_valid (r_addr_valid),
    .dest_match (dest_match),
    .dest_bcast (dest_bcast)
  );

  assign mac        = r_mac;
  assign ip         = r_ip;
  assign addr_valid = r_addr_valid;
  assign load_err   = r_load_err;

endmodule

// File: tb/tb_address_capture.sv
// Directed checks of address loading, overflow, reset and destination matching.
module tb_address_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [8:0]  address_set = 9'd0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic [47:0] mac;
  logic [31:0] ip;
  logic        addr_valid;
  logic        load_err;
  logic        dest_match;
  logic        dest_bcast;

  int n_tests = 0;
  int n_fail  = 0;

  address_capture #(.PROMISC(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .address_set (address_set),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .mac         (mac),
    .ip          (ip),
    .addr_valid  (addr_valid),
    .load_err    (load_err),
    .dest_match  (dest_match),
    .dest_bcast  (dest_bcast)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic load_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) tick();
    address_set = {1'b1, b};
    tick();
    address_set = 9'd0;
  endtask

  task automatic send_frame(input string tag, input logic [47:0] dst, input int nbytes,
                            input logic exp_m, input logic exp_b);
    logic stray;
    stray = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      rx_dv   = 1'b1;
      rx_data = dst[47-8*i -: 8];
      tick();
      if (i < 5 && (dest_match || dest_bcast)) stray = 1'b1;
      if (i == 5) begin
        check({tag, "_match"}, {79'd0, dest_match}, {79'd0, exp_m});
        check({tag, "_bcast"}, {79'd0, dest_bcast}, {79'd0, exp_b});
      end
    end
    rx_dv   = 1'b0;
    rx_data = 8'd0;
    tick();
    if (dest_match || dest_bcast) stray = 1'b1;
    check({tag, "_stray"}, {79'd0, stray}, 80'd0);
  endtask

  logic [7:0] load_vec [0:9] = '{8'h12, 8'h55, 8'h55, 8'h00, 8'h01, 8'h2a, 8'h80, 8'h03, 8'h80, 8'hac};
  int         gap_vec  [0:9] = '{0, 2, 1, 3, 0, 1, 4, 0, 2, 1};
  logic [7:0] fresh_vec[0:9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hc0, 8'ha8, 8'h00, 8'h07};

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    check("rst_mac",  {32'd0, mac}, 80'd0);
    check("rst_ip",   {48'd0, ip}, 80'd0);
    check("rst_valid", {79'd0, addr_valid}, 80'd0);
    check("rst_err",  {79'd0, load_err}, 80'd0);
    check("rst_pulses", {78'd0, dest_match, dest_bcast}, 80'd0);

    // mac==0 but no address loaded: equal bytes must not match
    send_frame("zero_noload", 48'h000000000000, 6, 1'b0, 1'b0);
    send_frame("bcast_noload", 48'hffffffffffff, 6, 1'b0, 1'b1);

    for (int i = 0; i < 9; i++) load_byte(load_vec[i], gap_vec[i]);
    check("partial_valid", {79'd0, addr_valid}, 80'd0);
    check("partial_mac", {32'd0, mac}, 80'd0);
    load_byte(load_vec[9], gap_vec[9]);
    check("load_valid", {79'd0, addr_valid}, 80'd1);
    check("load_mac", {32'd0, mac}, {32'd0, 48'h12555500012a});
    check("load_ip", {48'd0, ip}, {48'd0, 32'h800380ac});

    send_frame("match", 48'h12555500012a, 6, 1'b1, 1'b0);
    send_frame("bcast", 48'hffffffffffff, 6, 1'b0, 1'b1);
    send_frame("last_byte_diff", 48'h12555500012b, 6, 1'b0, 1'b0);
    send_frame("first_byte_diff", 48'h13555500012a, 6, 1'b0, 1'b0);
    send_frame("short", 48'h12555500012a, 4, 1'b0, 1'b0);
    send_frame("after_short", 48'h12555500012a, 6, 1'b1, 1'b0);

    load_byte(8'h77, 0);
    check("ovf_err", {79'd0, load_err}, 80'd1);
    check("ovf_mac", {32'd0, mac}, {32'd0, 48'h12555500012a});
    check("ovf_ip", {48'd0, ip}, {48'd0, 32'h800380ac});
    check("ovf_valid", {79'd0, addr_valid}, 80'd1);

    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_err", {79'd0, load_err}, 80'd0);
    check("rst2_valid", {79'd0, addr_valid}, 80'd0);
    for (int i = 0; i < 7; i++) load_byte(8'haa + 8'(i), 1);
    // Reset with a strobe held in the same cycle: the strobe must be discarded
    rst = 1'b0;
    address_set = {1'b1, 8'h99};
    tick();
    address_set = 9'd0;
    rst = 1'b1;
    check("midrst_mac", {32'd0, mac}, 80'd0);
    for (int i = 0; i < 9; i++) load_byte(fresh_vec[i], i % 3);
    check("fresh_partial_valid", {79'd0, addr_valid}, 80'd0);
    load_byte(fresh_vec[9], 0);
    check("fresh_mac", {32'd0, mac}, {32'd0, 48'h010203040506});
    check("fresh_ip", {48'd0, ip}, {48'd0, 32'hc0a80007});
    check("fresh_valid", {79'd0, addr_valid}, 80'd1);
    check("fresh_err", {79'd0, load_err}, 80'd0);
    send_frame("fresh_match", 48'h010203040506, 6, 1'b1, 1'b0);
    send_frame("old_mac", 48'h12555500012a, 6, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
